// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed common-anode 7-segment scanner with per-digit decimal
// point, blanking, blinking, leading-zero suppression and 8-level brightness.
module seg_scan_mux #(
    parameter int DIGITS    = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    input  logic [2:0]            bright,
    output logic [DIGITS-1:0]     sel,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic                  frame_tick
);

    localparam int ON_STEP = (SCAN_DIV - BLANK_CYC) / 8;
    localparam int CW      = $clog2(SCAN_DIV + 1);
    localparam int IW      = $clog2(DIGITS);
    localparam int BW      = $clog2(BLINK_DIV);

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);
    localparam logic [CW-1:0] STEP       = CW'(ON_STEP);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
        endcase
    endfunction

    logic [CW-1:0] slot_cnt;
    logic [IW-1:0] idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          wrap_d;
    logic          slot_last;
    logic          slot_start;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign slot_start = (slot_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            wrap_d      <= 1'b0;
        end else if (!en) begin
            slot_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            wrap_d      <= 1'b0;
        end else begin
            // wrap_d marks the first cycle of digit 0 after a full frame
            wrap_d <= slot_last && (idx == IDX_LAST);
            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    logic [DIGITS-1:0] nz_mask;
    logic [3:0]        live_nib;
    logic              live_dp;
    logic              live_blank;
    logic              live_blink;
    logic              live_supp;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nz_mask = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nz_mask[i] = |disp_data[4*i +: 4];
        end
        live_nib   = 4'(disp_data >> {idx, 2'b00});
        live_dp    = dp[idx];
        live_blank = blank_mask[idx];
        live_blink = blink_mask[idx];
        live_supp  = lz_en && (idx != '0) && ((nz_mask >> idx) == '0);
    end

    logic [3:0] snap_nib;
    logic       snap_dp;
    logic       snap_blank;
    logic       snap_blink;
    logic       snap_supp;
    logic [2:0] snap_bright;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_nib    <= '0;
            snap_dp     <= 1'b0;
            snap_blank  <= 1'b0;
            snap_blink  <= 1'b0;
            snap_supp   <= 1'b0;
            snap_bright <= '0;
        end else if (slot_start) begin
            snap_nib    <= live_nib;
            snap_dp     <= live_dp;
            snap_blank  <= live_blank;
            snap_blink  <= live_blink;
            snap_supp   <= live_supp;
            snap_bright <= bright;
        end
    end

    // During the capture cycle itself the snapshot register is not yet loaded,
    // so the live values stand in for it.
    logic [3:0]    cur_nib;
    logic          cur_dp;
    logic          cur_blank;
    logic          cur_blink;
    logic          cur_supp;
    logic [2:0]    cur_bright;
    logic [CW-1:0] on_end;
    logic          in_window;
    logic          dark;

    always_comb begin
        cur_nib    = slot_start ? live_nib   : snap_nib;
        cur_dp     = slot_start ? live_dp    : snap_dp;
        cur_blank  = slot_start ? live_blank : snap_blank;
        cur_blink  = slot_start ? live_blink : snap_blink;
        cur_supp   = slot_start ? live_supp  : snap_supp;
        cur_bright = slot_start ? bright     : snap_bright;
        on_end     = BLANK_END + STEP * (CW'(cur_bright) + CW'(1));
        in_window  = (slot_cnt >= BLANK_END) && (slot_cnt < on_end);
        dark       = !en || !in_window || cur_blank || (cur_blink && blink_phase)
                     || (cur_supp && !cur_dp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '1;
            seg        <= 7'h7F;
            seg_dp     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= en && wrap_d;
            if (dark) begin
                sel    <= '1;
                seg    <= 7'h7F;
                seg_dp <= 1'b1;
            end else begin
                sel    <= ~(DIGITS'(1) << idx);
                seg    <= cur_supp ? 7'h7F : hex7(cur_nib);
                seg_dp <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: cycle model feeding a scoreboard plus
// directed scenario tasks with hand-derived expectations.
module tb_seg_scan_mux;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 16;
    localparam int BLANK_CYC = 4;
    localparam int BLINK_DIV = 64;
    localparam int ON_STEP   = (SCAN_DIV - BLANK_CYC) / 8;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        en         = 1'b0;
    logic [15:0] disp_data  = 16'h0;
    logic [3:0]  dp         = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic        lz_en      = 1'b0;
    logic [2:0]  bright     = 3'd7;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } out_t;

    out_t exp_q[$];
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_mux #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .disp_data  (disp_data),
        .dp         (dp),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .bright     (bright),
        .sel        (sel),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: at each edge, predict what the outputs register, then advance.
    initial begin : model
        int   m_slot;
        int   m_idx;
        int   m_bcnt;
        bit   m_phase;
        bit   m_pend;
        logic [3:0] s_nib;
        bit   s_dp, s_blank, s_blink, s_supp, nz, on, dark;
        int   s_bright;
        out_t e;
        m_slot = 0; m_idx = 0; m_bcnt = 0; m_phase = 0; m_pend = 0;
        s_nib = 4'h0; s_dp = 0; s_blank = 0; s_blink = 0; s_supp = 0; s_bright = 0;
        forever begin
            @(posedge clk);
            if (!rst_n || !en) begin
                if (rst_n) begin
                    e.sel = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
                    exp_q.push_back(e);
                end
                m_slot = 0; m_idx = 0; m_bcnt = 0; m_phase = 0; m_pend = 0;
            end else begin
                if (m_slot == 0) begin
                    s_nib    = disp_data[4*m_idx +: 4];
                    s_dp     = dp[m_idx];
                    s_blank  = blank_mask[m_idx];
                    s_blink  = blink_mask[m_idx];
                    s_bright = int'(bright);
                    nz = 0;
                    for (int j = m_idx; j < DIGITS; j++)
                        if (disp_data[4*j +: 4] != 4'h0) nz = 1;
                    s_supp = lz_en && (m_idx != 0) && !nz;
                end
                on   = (m_slot >= BLANK_CYC) && (m_slot < BLANK_CYC + ON_STEP * (s_bright + 1));
                dark = !on || s_blank || (s_blink && m_phase) || (s_supp && !s_dp);
                e.sel  = dark ? 4'hF : ~(4'b0001 << m_idx);
                e.seg  = (dark || s_supp) ? 7'h7F : hex_tab[s_nib];
                e.dp   = dark ? 1'b1 : ~s_dp;
                e.tick = m_pend;
                exp_q.push_back(e);
                m_pend = (m_slot == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
                if (m_slot == SCAN_DIV - 1) begin
                    m_slot = 0;
                    m_idx  = (m_idx + 1) % DIGITS;
                end else begin
                    m_slot = m_slot + 1;
                end
                if (m_bcnt == BLINK_DIV - 1) begin
                    m_bcnt  = 0;
                    m_phase = !m_phase;
                end else begin
                    m_bcnt = m_bcnt + 1;
                end
            end
        end
    end

    initial begin : scoreboard
        out_t e, a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {sel, seg, seg_dp, frame_tick};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got sel=%b seg=%h dp=%b tick=%b want sel=%b seg=%h dp=%b tick=%b",
                             $time, a.sel, a.seg, a.dp, a.tick, e.sel, e.seg, e.dp, e.tick);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Pulse en low for one edge so the scan restarts at idx 0, slot 0; returns at sample s=0.
    task automatic restart();
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_tick;
        rst_n = 1'b0; en = 1'b1; disp_data = 16'h1234; bright = 3'd7;
        repeat (3) @(negedge clk);
        checks++;
        if ({sel, seg, seg_dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got sel=%b seg=%h dp=%b tick=%b", sel, seg, seg_dp, frame_tick);
        end
        rst_n = 1'b1;
        for (int s = 1; s <= 130; s++) begin
            @(negedge clk);
            if (s <= 4 || (s >= 13 && s <= 20)) begin
                checks++;
                if (sel !== 4'hF) begin
                    errors++;
                    $display("FAIL scan_dark s=%0d got sel=%b want 1111", s, sel);
                end
            end else if (s <= 12) begin
                checks++;
                if ({sel, seg} !== {4'hE, 7'h19}) begin
                    errors++;
                    $display("FAIL scan_digit0 s=%0d got sel=%b seg=%h want 1110/19", s, sel, seg);
                end
            end else if (s <= 28) begin
                checks++;
                if ({sel, seg} !== {4'hD, 7'h30}) begin
                    errors++;
                    $display("FAIL scan_digit1 s=%0d got sel=%b seg=%h want 1101/30", s, sel, seg);
                end
            end
            exp_tick = (s == 65) || (s == 129);
            checks++;
            if (frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL frame_tick s=%0d got %b want %b", s, frame_tick, exp_tick);
            end
        end
    endtask

    task automatic test_brightness();
        int c0, c1;
        logic [2:0] levels [2];
        int want [2];
        levels[0] = 3'd0; levels[1] = 3'd3;
        want[0] = 1; want[1] = 4;
        for (int k = 0; k < 2; k++) begin
            bright = levels[k];
            restart();
            c0 = 0; c1 = 0;
            for (int s = 1; s <= 31; s++) begin
                @(negedge clk);
                if (sel == 4'hE) c0++;
                if (sel == 4'hD) c1++;
            end
            checks++;
            if (c0 != want[k] || c1 != want[k]) begin
                errors++;
                $display("FAIL bright_%0d got lit %0d/%0d want %0d", levels[k], c0, c1, want[k]);
            end
        end
        bright = 3'd3;
        restart();
        c0 = 0; c1 = 0;
        for (int s = 1; s <= 31; s++) begin
            @(negedge clk);
            if (sel == 4'hE) c0++;
            if (sel == 4'hD) c1++;
            if (s == 6) bright = 3'd7;
        end
        checks++;
        if (c0 != 4 || c1 != 8) begin
            errors++;
            $display("FAIL bright_midslot got lit %0d/%0d want 4/8", c0, c1);
        end
    endtask

    task automatic test_lzs();
        int c0, c1, c2, c3;
        disp_data = 16'h0050; lz_en = 1'b1; bright = 3'd7; dp = 4'h0;
        restart();
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int s = 1; s <= 63; s++) begin
            @(negedge clk);
            if ({sel, seg} == {4'hE, 7'h40}) c0++;
            if ({sel, seg} == {4'hD, 7'h12}) c1++;
            if (sel[2] == 1'b0) c2++;
            if (sel[3] == 1'b0) c3++;
        end
        checks++;
        if (c2 != 0 || c3 != 0) begin
            errors++;
            $display("FAIL lzs_dark got lit digit2=%0d digit3=%0d want 0/0", c2, c3);
        end
        checks++;
        if (c0 != 8 || c1 != 8) begin
            errors++;
            $display("FAIL lzs_shown got digit0=%0d digit1=%0d want 8/8", c0, c1);
        end
        dp = 4'b1000;
        restart();
        c2 = 0; c3 = 0;
        for (int s = 1; s <= 63; s++) begin
            @(negedge clk);
            if ({sel, seg, seg_dp} == {4'h7, 7'h7F, 1'b0}) c3++;
            if (sel[2] == 1'b0) c2++;
        end
        checks++;
        if (c3 != 8 || c2 != 0) begin
            errors++;
            $display("FAIL lzs_dot got dot_only=%0d digit2=%0d want 8/0", c3, c2);
        end
        dp = 4'h0; lz_en = 1'b0;
    endtask

    task automatic test_blink_blank();
        int lit [3];
        int c1, c2, c3;
        disp_data = 16'h1234; blink_mask = 4'b0001; blank_mask = 4'h0; bright = 3'd7;
        restart();
        lit[0] = 0; lit[1] = 0; lit[2] = 0; c1 = 0;
        for (int s = 1; s <= 191; s++) begin
            @(negedge clk);
            if (sel == 4'hE) lit[(s - 1) / 64]++;
            if (sel == 4'hD) c1++;
        end
        checks++;
        if (lit[0] != 8 || lit[1] != 0 || lit[2] != 8) begin
            errors++;
            $display("FAIL blink got %0d/%0d/%0d want 8/0/8", lit[0], lit[1], lit[2]);
        end
        checks++;
        if (c1 != 24) begin
            errors++;
            $display("FAIL blink_other got %0d want 24", c1);
        end
        blink_mask = 4'h0; blank_mask = 4'b1000;
        restart();
        c2 = 0; c3 = 0;
        for (int s = 1; s <= 127; s++) begin
            @(negedge clk);
            if (sel[3] == 1'b0) c3++;
            if (sel == 4'hB) c2++;
        end
        checks++;
        if (c3 != 0 || c2 != 16) begin
            errors++;
            $display("FAIL blank got digit3=%0d digit2=%0d want 0/16", c3, c2);
        end
        blank_mask = 4'h0;
    endtask

    task automatic test_enable();
        int ticks;
        disp_data = 16'h1234; bright = 3'd7;
        restart();
        repeat (7) @(negedge clk);
        checks++;
        if (sel !== 4'hE) begin
            errors++;
            $display("FAIL en_lit_before got sel=%b want 1110", sel);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({sel, seg, seg_dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL en_drop got sel=%b seg=%h dp=%b want 1111/7f/1", sel, seg, seg_dp);
        end
        repeat (5) @(negedge clk);
        en = 1'b1;
        ticks = 0;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
            if (s == 4) begin
                checks++;
                if (sel !== 4'hF) begin
                    errors++;
                    $display("FAIL en_restart_dark got sel=%b want 1111", sel);
                end
            end
            if (s == 5) begin
                checks++;
                if ({sel, seg} !== {4'hE, 7'h19}) begin
                    errors++;
                    $display("FAIL en_restart_lit got sel=%b seg=%h want 1110/19", sel, seg);
                end
            end
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL en_restart_tick got %0d pulses want 0", ticks);
        end
    endtask

    task automatic test_async_reset();
        disp_data = 16'h1234; bright = 3'd7;
        restart();
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, seg, seg_dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got sel=%b seg=%h dp=%b tick=%b want 1111/7f/1/0",
                     sel, seg, seg_dp, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({sel, seg} !== {4'hE, 7'h19}) begin
            errors++;
            $display("FAIL async_reset_resume got sel=%b seg=%h want 1110/19", sel, seg);
        end
    endtask

    // Random input churn, including mid-slot changes and enable drops; the scoreboard judges it.
    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 15))
                0: disp_data  = 16'($urandom) & 16'($urandom);
                1: dp         = 4'($urandom);
                2: blank_mask = 4'($urandom) & 4'($urandom);
                3: blink_mask = 4'($urandom);
                4: lz_en      = 1'($urandom);
                5: bright     = 3'($urandom);
                6: en         = ($urandom_range(0, 7) != 0);
                default: ;
            endcase
        end
        en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin : main
        test_reset();
        test_brightness();
        test_lzs();
        test_blink_blank();
        test_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parameterised multiplexed 7-segment display driver: scans DIGITS common-anode digits and adds per-digit decimal points, blanking, blinking, leading-zero suppression, 8-level brightness and anti-ghosting blanking. It sits between the clock/counter logic (BCD/hex nibbles) and the board display pins. It is the general-purpose successor to the fixed 6-digit hex scanner.

## Interface
- DIGITS, 6: number of digits, legal 2..8.
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz slot rate at 50 MHz).
- BLANK_CYC, 500: dark cycles at the start of every slot; must satisfy BLANK_CYC + 8 ≤ SCAN_DIV.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  display enable; low = all dark, counters held at 0.
- disp_data  in  4*DIGITS  digit i = disp_data[4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS  per-digit decimal point, active high.
- blank_mask  in  DIGITS  1 = digit forced dark.
- blink_mask  in  DIGITS  1 = digit blinks.
- lz_en  in  1  leading-zero suppression enable.
- bright  in  3  brightness 0 (dimmest) .. 7 (brightest).
- sel  out  DIGITS  digit select, active low; all ones = none.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- seg_dp  out  1  decimal point, active low.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

## Operation
- slot_cnt counts 0..SCAN_DIV-1 and wraps. idx (0..DIGITS-1) increments when slot_cnt = SCAN_DIV-1 and wraps DIGITS-1 → 0.
- blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles on wrap.
- ON_STEP = (SCAN_DIV-BLANK_CYC)/8 (integer, elaboration-time). The slot is on while BLANK_CYC ≤ slot_cnt < BLANK_CYC + ON_STEP*(bright+1).
- Slot snapshot: at slot_cnt = 0, the nibble, dp, blank, blink and suppress flags for the new idx, and bright, are captured. Input changes mid-slot do not affect the current slot.
- Suppress: lz_en=1, idx≠0, and nibbles idx..DIGITS-1 are all zero. Digit 0 is never suppressed.
- Digit is dark if any of these hold: not in the on window; blank_mask[idx]; (blink_mask[idx] and blink_phase=1); (suppress and dp[idx]=0).
- Dark digit: sel all ones, seg 7'h7F, seg_dp 1.
- Lit digit: sel has only bit idx low. seg is the decoded nibble, or 7'h7F if suppressed with dp set (dot only). seg_dp = ~dp[idx].
- Decode (hex, active low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
- frame_tick: high for exactly one cycle coinciding with the first output cycle of digit 0 after an idx wrap. It does not fire after reset or on an en rising edge.
- en low: slot_cnt, idx, blink_cnt and blink_phase are cleared synchronously; outputs go dark one cycle later. After en rises, scanning restarts at idx 0, slot_cnt 0.

## Timing
- Reset values: sel all ones, seg 7'h7F, seg_dp 1, frame_tick 0; internally slot_cnt=0, idx=0, blink_phase=0.
- All outputs are registered. Outputs in cycle n+1 reflect the counter state and snapshot of cycle n (1-cycle latency).
- After reset release with en=1: outputs are dark for BLANK_CYC+1 cycles, then digit 0 is lit for ON_STEP*(bright+1) cycles.
- Slot period is exactly SCAN_DIV cycles; frame period is DIGITS*SCAN_DIV cycles, independent of masks and bright.
- At most one sel bit is low in any cycle. The digit change always falls inside BLANK_CYC dark cycles (no ghosting).
- Reset asserted mid-slot forces reset values immediately (asynchronous).
- bright, dp and mask changes take effect at the next slot boundary, never mid-slot.

## Test plan
Common parameters: DIGITS=4, SCAN_DIV=16, BLANK_CYC=4, BLINK_DIV=64 (ON_STEP=1).
- Reset and basic scan: disp_data=16'h1234, bright=7, masks 0, en=1.
  - Dark 5 cycles after reset release.
  - Then sel=4'b1110, seg=7'h19 for 8 cycles.
  - Digit 1 (sel=4'b1101, seg=7'h30) starts 16 cycles after digit 0.
  - frame_tick fires every 64 cycles.
- Brightness: bright=0 → each digit lit for 1 cycle per slot. bright=3 → 4 cycles. Change bright mid-slot → takes effect next slot only.
- Leading-zero suppression: disp_data=16'h0050, lz_en=1.
  - Digits 3 and 2 stay dark for the whole slot.
  - Digit 1 shows 7'h12, digit 0 shows 7'h40.
  - Set dp[3]=1 → digit 3 shows seg 7'h7F, seg_dp 0.
- Blink/blank: blink_mask=4'b0001 → digit 0 dark during the half-periods where blink_phase=1, lit otherwise. blank_mask=4'b1000 → sel[3] never low.
- Enable: drop en mid-slot → all outputs dark next cycle. Raise en → digit 0 lit after BLANK_CYC+1 cycles; no frame_tick at restart.
- Async reset mid-lit-slot → sel=4'b1111, seg=7'h7F in the same cycle, without waiting for a clk edge.
